// File: rtl/de_hazard_ctrl_pkg.sv
// Shared constants and types for the decode-stage issue controller and its scoreboard.
package de_hazard_ctrl_pkg;

  localparam int REGNOBITS    = 5;
  localparam int SB_CNT_BITS  = 2;
  localparam int SB_CNT_MAX   = (1 << SB_CNT_BITS) - 1;
  // Cycles after reset release in which a WB to an idle counter is tolerated.
  localparam int SB_RST_GUARD = 3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_BR_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/de_scoreboard.sv
// Per-register pending-write counters: +1 on issue of a writer, -1 on WB, sticky underflow flag.
// Latency: counts visible the cycle after the edge; no backpressure (counter saturates, never wraps).
module de_scoreboard
  import de_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_BITS = SB_CNT_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               inc_vld_i,
  input  logic [REGNOBITS-1:0]               inc_rd_i,
  input  logic                               dec_vld_i,
  input  logic [REGNOBITS-1:0]               dec_rd_i,
  output logic [NUM_REGS-1:0][CNT_BITS-1:0]  cnt_o,
  output logic [NUM_REGS-1:0]                busy_vec_o,
  output logic                               uf_err_o
);

  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;
  localparam logic [1:0]          GUARD_INIT = 2'(SB_RST_GUARD);

  logic [NUM_REGS-1:0][CNT_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_REGS-1:0]               inc_hit, dec_hit;
  logic [1:0]                        guard_q, guard_d;
  logic                              uf_q, uf_d;

  // x0 is never tracked, so both decoders start at register 1.
  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_hit[r] = inc_vld_i && (inc_rd_i == REGNOBITS'(r));
      dec_hit[r] = dec_vld_i && (dec_rd_i == REGNOBITS'(r));
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    uf_d    = uf_q;
    guard_d = (guard_q != 2'd0) ? guard_q - 2'd1 : guard_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (inc_hit[r] && !dec_hit[r]) begin
        if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_hit[r] && !inc_hit[r]) begin
        if (cnt_q[r] != '0)         cnt_d[r] = cnt_q[r] - 1'b1;
        else if (guard_q == 2'd0)   uf_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      uf_q    <= 1'b0;
      guard_q <= GUARD_INIT;
    end else begin
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
      guard_q <= guard_d;
    end
  end

  always_comb begin
    busy_vec_o = '0;
    for (int r = 1; r < NUM_REGS; r++) busy_vec_o[r] = |cnt_q[r];
  end

  assign cnt_o    = cnt_q;
  assign uf_err_o = uf_q;

endmodule

// File: rtl/de_hazard_ctrl.sv
// Decode issue control: RAW/WAW hazard check against the scoreboard, branch-wait FSM, stall/flush.
// Latency: outputs are combinational from state and inputs; backpressure is stall_de/stall_fe.
module de_hazard_ctrl
  import de_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_BITS = SB_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [4:0]           de_rs1,
  input  logic [4:0]           de_rs2,
  input  logic                 de_rs1_used,
  input  logic                 de_rs2_used,
  input  logic [4:0]           de_rd,
  input  logic                 de_wr_reg,
  input  logic                 de_is_br,
  input  logic                 agex_br_resolve,
  input  logic                 agex_br_taken,
  input  logic                 wb_wr_reg,
  input  logic [4:0]           wb_rd,
  output logic                 de_issue,
  output logic                 stall_de,
  output logic                 stall_fe,
  output logic                 flush_de,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic                 sb_err
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0]               rs1_cnt, rs2_cnt, rd_cnt;
  logic                              haz_rs1, haz_rs2, haz_waw, hazard;
  logic                              uf_err;
  ctrl_state_e                       state_q, state_d;
  logic                              br_err_q, br_err_d;

  de_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_BITS (CNT_BITS)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .inc_vld_i  (de_issue && de_wr_reg),
    .inc_rd_i   (de_rd),
    .dec_vld_i  (wb_wr_reg),
    .dec_rd_i   (wb_rd),
    .cnt_o      (cnt),
    .busy_vec_o (busy_vec),
    .uf_err_o   (uf_err)
  );

  assign rs1_cnt = cnt[de_rs1];
  assign rs2_cnt = cnt[de_rs2];
  assign rd_cnt  = cnt[de_rd];

  // A last outstanding write landing in WB this cycle is forwarded by the write-through regfile.
  always_comb begin
    haz_rs1 = de_rs1_used && (de_rs1 != '0) && (rs1_cnt != '0) &&
              !(wb_wr_reg && (wb_rd == de_rs1) && (rs1_cnt == CNT_ONE));
    haz_rs2 = de_rs2_used && (de_rs2 != '0) && (rs2_cnt != '0) &&
              !(wb_wr_reg && (wb_rd == de_rs2) && (rs2_cnt == CNT_ONE));
    haz_waw = de_wr_reg && (rd_cnt == CNT_MAX);
    hazard  = haz_rs1 || haz_rs2 || haz_waw;
  end

  always_comb begin
    state_d  = state_q;
    br_err_d = br_err_q;
    flush_de = (state_q == ST_BR_WAIT) && agex_br_resolve && agex_br_taken;
    de_issue = de_valid && !hazard && (state_q == ST_IDLE) && !flush_de;
    stall_de = de_valid && !de_issue && !flush_de;
    stall_fe = stall_de || (state_q == ST_BR_WAIT);
    case (state_q)
      ST_IDLE: begin
        if (agex_br_resolve)       br_err_d = 1'b1;
        if (de_issue && de_is_br)  state_d  = ST_BR_WAIT;
      end
      ST_BR_WAIT: begin
        if (agex_br_resolve)       state_d  = ST_IDLE;
      end
      default:                     state_d  = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      br_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      br_err_q <= br_err_d;
    end
  end

  assign sb_err = br_err_q || uf_err;

endmodule
